// File: rtl/ring_pulse_controller.sv
// rtl/ring_pulse_controller.sv - frame-synchronous grow/hold/shrink sequencer for the OLED ring renderer
//
// Purpose: steps the ring's inner radius through a grow / hold / shrink
// animation and presents the inner and outer squared radii plus an enable to
// the ring pixel datapath. Every geometry change is applied only on the frame
// step edge, so each frame is drawn with one consistent ring.
//
// Ports:
//   clk25       - pixel clock, the only clock
//   reset       - asynchronous active-high reset
//   pixel_index - current OLED pixel 0..6143, wraps 6143 -> 0
//   start       - one-cycle request to begin the animation (honoured in IDLE)
//   stop        - one-cycle request to abort the animation
//   loop        - level; restart growing instead of idling after a shrink
//   ring_en     - renderer draws the ring when high, black when low
//   inner_sq    - inner radius squared
//   outer_sq    - (inner radius + THICK) squared
//   radius      - current inner radius
//   busy        - animation running or a start is armed
//   frame_tick  - one-cycle pulse on the cycle after every frame step

module ring_pulse_controller #(
    parameter int R_MIN           = 4,
    parameter int R_MAX           = 28,
    parameter int THICK           = 2,
    parameter int FRAMES_PER_STEP = 4,
    parameter int HOLD_FRAMES     = 30
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic [12:0] pixel_index,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic        ring_en,
    output logic [12:0] inner_sq,
    output logic [12:0] outer_sq,
    output logic [5:0]  radius,
    output logic        busy,
    output logic        frame_tick
);

    localparam logic [12:0] LAST_PIX  = 13'd6143;
    localparam logic [5:0]  RMIN6     = 6'(R_MIN);
    localparam logic [5:0]  RMAX6     = 6'(R_MAX);
    localparam logic [5:0]  THICK6    = 6'(THICK);
    localparam logic [15:0] FPS16     = 16'(FRAMES_PER_STEP);
    localparam logic [15:0] HOLD16    = 16'(HOLD_FRAMES);
    localparam logic [12:0] RST_INNER = 13'(R_MIN * R_MIN);
    localparam logic [12:0] RST_OUTER = 13'((R_MIN + THICK) * (R_MIN + THICK));

    typedef enum logic [1:0] {
        IDLE,
        GROW,
        HOLD,
        SHRINK
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [12:0] prev_idx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [5:0]  radius_nx;
    logic        armed;
    logic        abort;
    logic        fs;
    logic        kill;
    logic        go;

    // Widen before multiplying so 63*63 = 3969 fits without truncation.
    function automatic logic [12:0] sq(input logic [5:0] r);
        logic [12:0] w;
        w = {7'd0, r};
        return w * w;
    endfunction

    // Frame step: first edge that sees the last pixel; holding on 6143 does
    // not retrigger because the previous index is then also 6143.
    assign fs = (pixel_index == LAST_PIX) && (prev_idx != LAST_PIX);

    // A stop on the frame-step cycle itself still counts, as does a start
    // landing on that cycle; stop always wins over start.
    assign kill = abort | stop;
    assign go   = (armed | start) & ~kill;

    always_comb begin
        state_nx  = state;
        radius_nx = radius;
        cnt_nx    = cnt;
        ring_en   = (state != IDLE);
        busy      = (state != IDLE) || armed;
        if (kill) begin
            state_nx  = IDLE;
            radius_nx = RMIN6;
            cnt_nx    = '0;
        end else begin
            case (state)
                IDLE: begin
                    radius_nx = RMIN6;
                    cnt_nx    = '0;
                    if (go) begin
                        state_nx = GROW;
                    end
                end
                GROW: begin
                    if (radius >= RMAX6) begin
                        // Degenerate R_MIN == R_MAX: nothing to grow.
                        state_nx = HOLD;
                        cnt_nx   = '0;
                    end else if (cnt + 16'd1 >= FPS16) begin
                        radius_nx = radius + 6'd1;
                        cnt_nx    = '0;
                        if (radius + 6'd1 == RMAX6) begin
                            state_nx = HOLD;
                        end
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt + 16'd1 >= HOLD16) begin
                        state_nx = SHRINK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                SHRINK: begin
                    if (radius <= RMIN6) begin
                        state_nx = loop ? GROW : IDLE;
                        cnt_nx   = '0;
                    end else if (cnt + 16'd1 >= FPS16) begin
                        radius_nx = radius - 6'd1;
                        cnt_nx    = '0;
                        if (radius - 6'd1 == RMIN6) begin
                            state_nx = loop ? GROW : IDLE;
                        end
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
                default: begin
                    state_nx  = IDLE;
                    radius_nx = RMIN6;
                    cnt_nx    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            radius     <= RMIN6;
            cnt        <= '0;
            inner_sq   <= RST_INNER;
            outer_sq   <= RST_OUTER;
            prev_idx   <= '0;
            armed      <= 1'b0;
            abort      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            prev_idx   <= pixel_index;
            frame_tick <= fs;
            if (fs) begin
                state    <= state_nx;
                radius   <= radius_nx;
                cnt      <= cnt_nx;
                inner_sq <= sq(radius_nx);
                outer_sq <= sq(radius_nx + THICK6);
                armed    <= 1'b0;
                abort    <= 1'b0;
            end else if (stop) begin
                abort <= 1'b1;
                armed <= 1'b0;
            end else if (start && (state == IDLE) && !abort) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ring_pulse_controller.sv
// tb/tb_ring_pulse_controller.sv - self-checking bench for ring_pulse_controller

module tb_ring_pulse_controller;

    logic        clk25;
    logic        reset;
    logic [12:0] pixel_index;
    logic        start;
    logic        stop;
    logic        loop;
    logic        ring_en;
    logic [12:0] inner_sq;
    logic [12:0] outer_sq;
    logic [5:0]  radius;
    logic        busy;
    logic        frame_tick;

    ring_pulse_controller #(
        .R_MIN(4),
        .R_MAX(8),
        .THICK(2),
        .FRAMES_PER_STEP(2),
        .HOLD_FRAMES(3)
    ) dut (
        .clk25(clk25),
        .reset(reset),
        .pixel_index(pixel_index),
        .start(start),
        .stop(stop),
        .loop(loop),
        .ring_en(ring_en),
        .inner_sq(inner_sq),
        .outer_sq(outer_sq),
        .radius(radius),
        .busy(busy),
        .frame_tick(frame_tick)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    typedef struct {
        logic [5:0] rad;
        logic       en;
    } exp_t;

    typedef struct {
        logic [5:0] rad_nl;
        logic       en_nl;
        logic [5:0] rad_lp;
        logic       en_lp;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[22];

    // Compressed frame: keeps the mid-frame indices the scenarios use and
    // the 6143 -> 0 wrap; the design only reacts to the last pixel.
    int seq[12] = '{0, 1, 2, 3, 100, 101, 3000, 3001, 6140, 6141, 6142, 6143};

    int rad_nl[22] = '{4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 8, 8, 8, 7, 7, 6, 6, 5, 5, 4, 4, 4};
    int rad_lp[22] = '{4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 8, 8, 8, 7, 7, 6, 6, 5, 5, 4, 4, 5};

    int         total;
    int         bad;
    logic [5:0] cur_rad;
    logic       cur_en;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " radius"}, int'(radius), 4);
        chk({tag, " inner_sq"}, int'(inner_sq), 16);
        chk({tag, " outer_sq"}, int'(outer_sq), 36);
        chk({tag, " ring_en"}, int'(ring_en), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " frame_tick"}, int'(frame_tick), 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk25);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals(tag);
        @(posedge clk25);
        #1;
        reset = 1'b0;
        cur_rad = 6'd4;
        cur_en  = 1'b0;
    endtask

    // One frame of stimulus; the expected post-step geometry is queued when
    // the last pixel is driven and checked when frame_tick reports the step.
    task automatic run_frame(input int start_at, input int stop_at,
                             input logic [5:0] exp_rad, input logic exp_en,
                             input logic exp_busy_mid, input string tag);
        int   ticks;
        int   r;
        exp_t e;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            pixel_index = 13'(seq[i]);
            start       = (seq[i] == start_at);
            stop        = (seq[i] == stop_at);
            if (seq[i] == 6143) begin
                e.rad = exp_rad;
                e.en  = exp_en;
                sb_q.push_back(e);
            end
            @(posedge clk25);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            if (seq[i] == 3000) begin
                chk({tag, " busy mid"}, int'(busy), int'(exp_busy_mid));
            end
            if (seq[i] == 6140) begin
                chk({tag, " radius stable"}, int'(radius), int'(cur_rad));
                chk({tag, " ring_en stable"}, int'(ring_en), int'(cur_en));
            end
            if (frame_tick) begin
                ticks++;
                if (sb_q.size() == 0) begin
                    chk({tag, " unexpected tick"}, 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    r = int'(e.rad);
                    chk({tag, " radius"}, int'(radius), r);
                    chk({tag, " ring_en"}, int'(ring_en), int'(e.en));
                    chk({tag, " inner_sq"}, int'(inner_sq), r * r);
                    chk({tag, " outer_sq"}, int'(outer_sq), (r + 2) * (r + 2));
                    chk({tag, " busy"}, int'(busy), int'(e.en));
                end
            end
        end
        chk({tag, " ticks per frame"}, ticks, 1);
        cur_rad = exp_rad;
        cur_en  = exp_en;
    endtask

    task automatic run_table(input bit use_loop, input int n, input string tag);
        logic [5:0] r;
        logic       en;
        for (int k = 0; k < n; k++) begin
            r  = use_loop ? tbl[k].rad_lp : tbl[k].rad_nl;
            en = use_loop ? tbl[k].en_lp : tbl[k].en_nl;
            run_frame((k == 0) ? 100 : -1, -1, r, en,
                      (k == 0) ? 1'b1 : cur_en, $sformatf("%s k%0d", tag, k));
        end
    endtask

    initial begin
        int ticks;
        int hold_seq[9];

        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        pixel_index = '0;
        start       = 1'b0;
        stop        = 1'b0;
        loop        = 1'b0;
        cur_rad     = 6'd4;
        cur_en      = 1'b0;

        for (int k = 0; k < 22; k++) begin
            tbl[k].rad_nl = 6'(rad_nl[k]);
            tbl[k].en_nl  = (k < 19);
            tbl[k].rad_lp = 6'(rad_lp[k]);
            tbl[k].en_lp  = 1'b1;
        end

        #5;
        chk_reset_vals("por");
        @(posedge clk25);
        #1;
        reset = 1'b0;

        // Scenario 1: reset mid-frame, then three idle frames.
        for (int i = 0; i < 6; i++) begin
            pixel_index = 13'(seq[i]);
            @(posedge clk25);
            #1;
        end
        pulse_reset("s1 reset");
        for (int f = 0; f < 3; f++) begin
            run_frame(-1, -1, 6'd4, 1'b0, 1'b0, $sformatf("s1 f%0d", f));
        end

        // Holding on the last pixel yields exactly one step; leaving and
        // returning yields the next.
        hold_seq = '{0, 6141, 6142, 6143, 6143, 6143, 6143, 0, 6143};
        ticks = 0;
        for (int i = 0; i < 9; i++) begin
            pixel_index = 13'(hold_seq[i]);
            @(posedge clk25);
            #1;
            if (frame_tick) ticks++;
        end
        chk("hold 6143 ticks", ticks, 2);

        // Scenario 2: full animation, loop low.
        pulse_reset("s2 reset");
        run_frame(-1, -1, 6'd4, 1'b0, 1'b0, "s2 idle");
        run_table(1'b0, 22, "s2");

        // Scenario 3: loop high re-enters grow.
        pulse_reset("s3 reset");
        loop = 1'b1;
        run_frame(-1, -1, 6'd4, 1'b0, 1'b0, "s3 idle");
        run_table(1'b1, 22, "s3");
        loop = 1'b0;

        // Scenario 4: stop during hold.
        pulse_reset("s4 reset");
        run_table(1'b0, 9, "s4");
        run_frame(-1, 3000, 6'd4, 1'b0, 1'b1, "s4 stop");
        run_frame(-1, -1, 6'd4, 1'b0, 1'b0, "s4 after");

        // Scenario 5: start and stop together; stop wins, flags then clear.
        pulse_reset("s5 reset");
        run_frame(100, 100, 6'd4, 1'b0, 1'b0, "s5 both");
        run_frame(-1, -1, 6'd4, 1'b0, 1'b0, "s5 idle");
        run_frame(100, -1, 6'd4, 1'b1, 1'b1, "s5 restart");

        // Scenario 6: asynchronous reset while growing at radius 6.
        pulse_reset("s6 reset");
        run_table(1'b0, 5, "s6");
        chk("s6 radius before reset", int'(radius), 6);
        pixel_index = 13'd0;
        @(posedge clk25);
        #1;
        pixel_index = 13'd1;
        @(posedge clk25);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("s6 async");
        @(posedge clk25);
        #1;
        reset   = 1'b0;
        cur_rad = 6'd4;
        cur_en  = 1'b0;
        run_frame(-1, -1, 6'd4, 1'b0, 1'b0, "s6 idle");
        run_table(1'b0, 3, "s6 again");

        chk("scoreboard drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
